// File: rtl/lstm_cell_update_pkg.sv
// Shared LSTM datapath definitions: Q9.7 constants, cell-update FSM states and packet layouts.
package lstm_cell_update_pkg;

    localparam int HIDDEN    = 8;
    localparam int XLEN      = 16;
    localparam int UW        = $clog2(HIDDEN);
    localparam int FRAC_BITS = 7;
    localparam logic [XLEN-1:0] Q_ONE = 16'h0080;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CELL,
        ST_TANH0,
        ST_TANH1,
        ST_HID,
        ST_OUT
    } state_t;

    typedef struct packed {
        logic [UW-1:0]   unit;
        logic            seq_start;
        logic [XLEN-1:0] f;
        logic [XLEN-1:0] i;
        logic [XLEN-1:0] g;
        logic [XLEN-1:0] o;
    } gate_pkt_t;

    typedef struct packed {
        logic [UW-1:0]   unit;
        logic [XLEN-1:0] h;
        logic [XLEN-1:0] c;
    } out_pkt_t;

    // Guards the cell-state file when HIDDEN is not a power of two.
    function automatic logic unit_in_range(input logic [UW-1:0] unit);
        return 32'(unit) < HIDDEN;
    endfunction

endpackage

// File: rtl/lstm_cell_update_if.sv
// Gate-packet input, tanh side-channel and result output of the LSTM cell-update stage.
interface lstm_cell_update_if;
    import lstm_cell_update_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [UW-1:0]   in_unit;
    logic            in_seq_start;
    logic [XLEN-1:0] in_f;
    logic [XLEN-1:0] in_i;
    logic [XLEN-1:0] in_g;
    logic [XLEN-1:0] in_o;

    logic [XLEN-1:0] tanh_data;
    logic [XLEN-1:0] tanh_result;

    logic            out_valid;
    logic            out_ready;
    logic [UW-1:0]   out_unit;
    logic [XLEN-1:0] out_h;
    logic [XLEN-1:0] out_c;

    // The cell-update block sits on the slave side.
    modport slave (
        input  in_valid, in_unit, in_seq_start, in_f, in_i, in_g, in_o,
        input  tanh_result, out_ready,
        output in_ready, tanh_data, out_valid, out_unit, out_h, out_c
    );

    modport master (
        output in_valid, in_unit, in_seq_start, in_f, in_i, in_g, in_o,
        output tanh_result, out_ready,
        input  in_ready, tanh_data, out_valid, out_unit, out_h, out_c
    );

endinterface

// File: rtl/lstm_cell_update_mult_q97.sv
// Combinational Q9.7 multiplier: full signed product, floor shift by the fraction bits, truncate.
module mult_q97
    import lstm_cell_update_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_p
);

    logic signed [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]          w_unused_bits;

    assign w_prod = $signed(i_a) * $signed(i_b);

    // Low XLEN bits of (prod >>> FRAC_BITS) are exactly this slice; no rounding or saturation.
    assign o_p = w_prod[FRAC_BITS +: XLEN];

    assign w_unused_bits = {w_prod[2*XLEN-1:FRAC_BITS+XLEN], w_prod[FRAC_BITS-1:0]};

endmodule

// File: rtl/lstm_cell_update.sv
// Per-hidden-unit LSTM state update: c = f*c_prev + i*g, round trip through tanh, h = o*tanh(c).
module lstm_cell_update
    import lstm_cell_update_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    lstm_cell_update_if.slave bus
);

    state_t          r_state;
    state_t          w_state_next;

    gate_pkt_t       r_pkt;
    logic [XLEN-1:0] r_c;
    logic [XLEN-1:0] r_th;
    logic [XLEN-1:0] r_h;

    logic            w_accept;
    logic            w_cell_en;
    logic            w_th_en;
    logic            w_h_en;

    logic            w_unit_ok;
    logic [XLEN-1:0] w_cmem_q [HIDDEN];
    logic [XLEN-1:0] w_c_prev;
    logic [XLEN-1:0] w_fc;
    logic [XLEN-1:0] w_ig;
    logic [XLEN-1:0] w_oh;
    logic [XLEN-1:0] w_c_new;
    out_pkt_t        w_out;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        w_accept      = 1'b0;
        w_cell_en     = 1'b0;
        w_th_en       = 1'b0;
        w_h_en        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_CELL;
                end
            end
            ST_CELL: begin
                w_cell_en    = 1'b1;
                w_state_next = ST_TANH0;
            end
            // The tanh unit captures its coefficients here; nothing to do but hold c_reg.
            ST_TANH0: begin
                w_state_next = ST_TANH1;
            end
            ST_TANH1: begin
                w_th_en      = 1'b1;
                w_state_next = ST_HID;
            end
            ST_HID: begin
                w_h_en       = 1'b1;
                w_state_next = ST_OUT;
            end
            ST_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pkt <= '0;
            r_c   <= '0;
            r_th  <= '0;
            r_h   <= '0;
        end else begin
            if (w_accept) begin
                r_pkt <= '{unit:      bus.in_unit,
                           seq_start: bus.in_seq_start,
                           f:         bus.in_f,
                           i:         bus.in_i,
                           g:         bus.in_g,
                           o:         bus.in_o};
            end
            if (w_cell_en) begin
                r_c <= w_c_new;
            end
            if (w_th_en) begin
                r_th <= bus.tanh_result;
            end
            if (w_h_en) begin
                r_h <= w_oh;
            end
        end
    end

    assign w_unit_ok = unit_in_range(r_pkt.unit);

    // Cell-state file as discrete registers so reset can clear every entry in one cycle.
    for (genvar gi = 0; gi < HIDDEN; gi++) begin : g_cmem
        logic [XLEN-1:0] r_entry;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_entry <= '0;
            end else if (w_cell_en && w_unit_ok && (r_pkt.unit == UW'(gi))) begin
                r_entry <= w_c_new;
            end
        end

        assign w_cmem_q[gi] = r_entry;
    end

    assign w_c_prev = (r_pkt.seq_start || !w_unit_ok) ? '0 : w_cmem_q[r_pkt.unit];

    mult_q97 u_mul_fc (
        .i_a (r_pkt.f),
        .i_b (w_c_prev),
        .o_p (w_fc)
    );

    mult_q97 u_mul_ig (
        .i_a (r_pkt.i),
        .i_b (r_pkt.g),
        .o_p (w_ig)
    );

    mult_q97 u_mul_oh (
        .i_a (r_pkt.o),
        .i_b (r_th),
        .o_p (w_oh)
    );

    assign w_c_new = w_fc + w_ig;

    assign w_out = '{unit: r_pkt.unit, h: r_h, c: r_c};

    assign bus.tanh_data = r_c;
    assign bus.out_unit  = w_out.unit;
    assign bus.out_h     = w_out.h;
    assign bus.out_c     = w_out.c;

endmodule

// File: tb/tb_lstm_cell_update.sv
// Directed bench for lstm_cell_update with a lookup-table tanh model.
module tb_lstm_cell_update;
    import lstm_cell_update_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    lstm_cell_update_if bus ();

    lstm_cell_update dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [15:0] tanh_model(input logic [15:0] x);
        case (x)
            16'h0040: return 16'h003B;
            16'h0080: return 16'h0061;
            16'h7FFF: return 16'h0080;
            16'hFE00: return 16'hFF80;
            default:  return 16'h0000;
        endcase
    endfunction

    always_comb bus.tanh_result = tanh_model(bus.tanh_data);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_pkt(input logic [2:0] unit, input logic seq,
                             input logic [15:0] f, input logic [15:0] i,
                             input logic [15:0] g, input logic [15:0] o);
        bus.in_valid     = 1'b1;
        bus.in_unit      = unit;
        bus.in_seq_start = seq;
        bus.in_f         = f;
        bus.in_i         = i;
        bus.in_g         = g;
        bus.in_o         = o;
    endtask

    // Call in IDLE with out_ready high; checks latency, tanh_data hold, results and release.
    task automatic run_pkt(input string tag, input logic [2:0] unit, input logic seq,
                           input logic [15:0] f, input logic [15:0] i,
                           input logic [15:0] g, input logic [15:0] o,
                           input logic [15:0] exp_c, input logic [15:0] exp_h);
        int n;
        drive_pkt(unit, seq, f, i, g, o);
        @(negedge clock);
        bus.in_valid = 1'b0;
        n = 1;
        check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        while (!bus.out_valid && n < 20) begin
            @(negedge clock);
            n++;
            if (n == 2 || n == 3) check({tag, "_tanh_data"}, 32'(bus.tanh_data), 32'(exp_c));
        end
        check({tag, "_latency"}, 32'(n), 32'd5);
        check({tag, "_out_c"}, 32'(bus.out_c), 32'(exp_c));
        check({tag, "_out_h"}, 32'(bus.out_h), 32'(exp_h));
        check({tag, "_out_unit"}, 32'(bus.out_unit), 32'(unit));
        $display("pkt %s unit=%0d c=%h h=%h", tag, bus.out_unit, bus.out_c, bus.out_h);
        @(negedge clock);
        check({tag, "_released"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ready_again"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int n;
        logic saw_valid;

        reset = 1'b1;
        bus.out_ready = 1'b1;
        drive_pkt(3'd0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_tanh_data", 32'(bus.tanh_data), 32'd0);
        check("rst_out_h", 32'(bus.out_h), 32'd0);
        check("rst_out_c", 32'(bus.out_c), 32'd0);
        check("rst_out_unit", 32'(bus.out_unit), 32'd0);

        // c = 0.5 from i*g with seq_start, then c_prev reuse on the same unit.
        run_pkt("first", 3'd2, 1'b1, 16'h0040, Q_ONE, 16'h0040, Q_ONE, 16'h0040, 16'h003B);
        run_pkt("reuse", 3'd2, 1'b0, Q_ONE, Q_ONE, 16'h0040, Q_ONE, 16'h0080, 16'h0061);
        // Unit 3 was never written, so c_prev = 0; h = 0.5*0x3B floors to 0x1D.
        run_pkt("fresh", 3'd3, 1'b0, Q_ONE, Q_ONE, 16'h0040, 16'h0040, 16'h0040, 16'h001D);

        // Backpressure: result held in OUT while a new packet waits at the input.
        bus.out_ready = 1'b0;
        drive_pkt(3'd1, 1'b1, 16'h0000, Q_ONE, Q_ONE, Q_ONE);
        @(negedge clock);
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("bp_latency", 32'(n), 32'd5);
        drive_pkt(3'd4, 1'b1, 16'h0000, Q_ONE, 16'h0040, Q_ONE);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_c", 32'(bus.out_c), 32'h0080);
            check("bp_out_h", 32'(bus.out_h), 32'h0061);
            check("bp_out_unit", 32'(bus.out_unit), 32'd1);
        end
        $display("pkt backpressure unit=%0d c=%h h=%h", bus.out_unit, bus.out_c, bus.out_h);
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("bp_consumed", 32'(bus.out_valid), 32'd0);
        check("bp_ready_after", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
        check("bp_accepted", 32'(bus.in_ready), 32'd0);
        n = 1;
        while (!bus.out_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("held_latency", 32'(n), 32'd5);
        check("held_out_c", 32'(bus.out_c), 32'h0040);
        check("held_out_h", 32'(bus.out_h), 32'h003B);
        check("held_out_unit", 32'(bus.out_unit), 32'd4);
        $display("pkt held unit=%0d c=%h h=%h", bus.out_unit, bus.out_c, bus.out_h);
        @(negedge clock);

        // Overflow: c_prev = 0x7FFF, f = 0x7FFF wraps to 0xFE00 rather than saturating.
        run_pkt("ovf_setup", 3'd5, 1'b1, 16'h0000, 16'h7FFF, Q_ONE, Q_ONE, 16'h7FFF, 16'h0080);
        run_pkt("ovf", 3'd5, 1'b0, 16'h7FFF, 16'h0000, 16'h0000, Q_ONE, 16'hFE00, 16'hFF80);

        // Reset during TANH1 drops the packet and clears the cell-state file.
        drive_pkt(3'd6, 1'b1, 16'h0000, Q_ONE, Q_ONE, Q_ONE);
        @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_mid_tanh1", 32'(bus.tanh_data), 32'h0080);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_idle", 32'(bus.in_ready), 32'd1);
        check("rst_mid_c", 32'(bus.tanh_data), 32'd0);
        reset = 1'b0;
        saw_valid = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (bus.out_valid) saw_valid = 1'b1;
        end
        check("rst_mid_no_valid", 32'(saw_valid), 32'd0);
        $display("pkt reset_mid_op out_valid_seen=%0d", saw_valid);
        // Unit 2 held 0x0080 before reset; a cleared file gives c = 0.
        run_pkt("post_rst", 3'd2, 1'b0, Q_ONE, 16'h0000, 16'h0000, Q_ONE, 16'h0000, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
